// File: rtl/apb_modport_slave.sv
// APB leaf slave: 16-slot word register file with byte-strobe writes, a read-only ID slot and error response.
// Optional build macro APB_SLAVE_WAIT_STATE_EN inserts one wait state between SETUP and ACCESS.
module apb_modport_slave #(
    parameter int          ADDR_WIDTH  = 3,
    parameter int          SEL_WIDTH   = 2,
    parameter int          SEL_INDEX   = 0,
    parameter int          WRITE_WIDTH = 32,
    parameter int          READ_WIDTH  = WRITE_WIDTH,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
    localparam int         STRB_WIDTH  = (WRITE_WIDTH + 7) / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH:0]    addr,
    input  logic [2:0]             prot,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic                   enable,
    input  logic                   write,
    input  logic [WRITE_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0]  strb,
    output logic                   ready,
    output logic [READ_WIDTH-1:0]  rdata,
    output logic                   slv_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        WAIT   = 2'd2,
        ACCESS = 2'd3
    } state_e;

    localparam int                      NUM_SLOTS = 2 ** (ADDR_WIDTH + 1);
    localparam int                      NUM_REGS  = NUM_SLOTS - 1;
    localparam logic [ADDR_WIDTH:0]     ID_SLOT   = '1;
    localparam logic [WRITE_WIDTH+31:0] ID_EXT    = {{WRITE_WIDTH{1'b0}}, ID_VALUE};
    localparam logic [WRITE_WIDTH-1:0]  ID_WORD   = ID_EXT[WRITE_WIDTH-1:0];

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH:0]    addr_q, addr_d;
    logic                   write_q, write_d;
    logic [WRITE_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  strb_q, strb_d;
    logic [2:0]             prot_q, prot_d;
    logic [WRITE_WIDTH-1:0] regs_q [NUM_REGS];
    logic [WRITE_WIDTH-1:0] regs_d [NUM_REGS];

    logic                   mysel_s;
    logic                   access_s;
    logic                   id_hit_s;
    logic                   priv_hit_s;
    logic                   err_s;
    logic                   commit_s;
    logic [WRITE_WIDTH-1:0] slot_val_s;
    logic                   prot_unused_s;

    // Bit-granular merge so a partial top byte is covered by the last strobe.
    function automatic logic [WRITE_WIDTH-1:0] merge_bytes(
        input logic [WRITE_WIDTH-1:0] old_v,
        input logic [WRITE_WIDTH-1:0] new_v,
        input logic [STRB_WIDTH-1:0]  be
    );
        logic [WRITE_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < WRITE_WIDTH; b++) begin
            if (be[b / 8]) begin
                res[b] = new_v[b];
            end else begin
                res[b] = old_v[b];
            end
        end
        return res;
    endfunction

    function automatic logic [READ_WIDTH-1:0] fit_read(input logic [WRITE_WIDTH-1:0] v);
        logic [READ_WIDTH-1:0] res;
        res = '0;
        for (int b = 0; b < READ_WIDTH; b++) begin
            if (b < WRITE_WIDTH) begin
                res[b] = v[b];
            end else begin
                res[b] = 1'b0;
            end
        end
        return res;
    endfunction

    assign mysel_s       = sel[SEL_INDEX];
    assign prot_unused_s = ^prot_q[2:1];

    // Next-state and transfer-capture logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        case (state_q)
            IDLE: begin
                if (mysel_s && !enable) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                addr_d  = addr;
                write_d = write;
                wdata_d = wdata;
                strb_d  = strb;
                prot_d  = prot;
                if (mysel_s && enable) begin
`ifdef APB_SLAVE_WAIT_STATE_EN
                    state_d = WAIT;
`else
                    state_d = ACCESS;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (mysel_s && !enable) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decode of the captured transfer: error classes and slot read value.
    always_comb begin
        access_s   = (state_q == ACCESS);
        id_hit_s   = (addr_q == ID_SLOT);
        priv_hit_s = addr_q[ADDR_WIDTH] && !id_hit_s;
        err_s      = (write_q && id_hit_s) || (!prot_q[0] && priv_hit_s);
        commit_s   = access_s && write_q && !err_s;
        if (id_hit_s) begin
            slot_val_s = ID_WORD;
        end else begin
            slot_val_s = regs_q[addr_q];
        end
    end

    // Register-file update at the completing edge; errored writes leave slots untouched.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && (addr_q == (ADDR_WIDTH + 1)'(i))) begin
                regs_d[i] = merge_bytes(regs_q[i], wdata_q, strb_q);
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Response outputs, active only for the single ACCESS cycle.
    always_comb begin
        ready   = access_s;
        slv_err = access_s && err_s;
        if (access_s && !err_s) begin
            rdata = fit_read(slot_val_s);
        end else begin
            rdata = '0;
        end
    end

    // State, captured transfer and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= 3'b000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            regs_q  <= regs_d;
        end
    end

endmodule

// File: tb/tb_apb_modport_slave.sv
// Directed self-checking bench for apb_modport_slave (honours APB_SLAVE_WAIT_STATE_EN for latency).
module tb_apb_modport_slave;

`ifdef APB_SLAVE_WAIT_STATE_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 2;
`endif
    localparam logic [31:0] ID_EXP = 32'hA5B0_0001;

    logic        clk;
    logic        reset;
    logic [3:0]  addr;
    logic [2:0]  prot;
    logic [1:0]  sel;
    logic        enable;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        ready;
    logic [31:0] rdata;
    logic        slv_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    apb_modport_slave dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .prot    (prot),
        .sel     (sel),
        .enable  (enable),
        .write   (write),
        .wdata   (wdata),
        .strb    (strb),
        .ready   (ready),
        .rdata   (rdata),
        .slv_err (slv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer: setup driven now (caller sits at a negedge), enable next cycle, poll for ready.
    // The bus is left in its access phase so a following call runs back-to-back.
    task automatic xfer(input string tag, input logic [3:0] a, input logic wr, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er, output int lat);
        logic done;
        sel = 2'b01; enable = 1'b0; addr = a; write = wr; wdata = d; strb = s; prot = p;
        @(posedge clk); #1;
        enable = 1'b1;
        done = 1'b0; lat = 0; rd = '0; er = 1'b0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (ready) begin
                done = 1'b1;
                rd   = rdata;
                er   = slv_err;
            end else begin
                done = 1'b0;
            end
        end
        check_val({tag, "_ready"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wr_chk(input string tag, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input logic exp_err);
        logic [31:0] rd; logic er; int lat;
        xfer(tag, a, 1'b1, d, s, p, rd, er, lat);
        check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [2:0] p,
                          input logic [31:0] exp_d, input logic exp_err);
        logic [31:0] rd; logic er; int lat;
        xfer(tag, a, 1'b0, 32'h0, 4'h0, p, rd, er, lat);
        check_val({tag, "_data"}, rd, exp_d);
        check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    task automatic bus_idle();
        sel = 2'b00; enable = 1'b0; write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd; logic er; int lat; int rdy_seen;
        reset = 1'b1; addr = 4'h0; prot = 3'b000; sel = 2'b00; enable = 1'b0;
        write = 1'b0; wdata = 32'h0; strb = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_err", {31'd0, slv_err}, 32'd0);
        check_val("rst_rdata", rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        rd_chk("rd3_rst", 4'd3, 3'b001, 32'h0, 1'b0);

        // Full write, latency measured from an idle bus.
        bus_idle();
        @(negedge clk);
        xfer("wr2_full", 4'd2, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, er, lat);
        check_val("wr2_full_err", {31'd0, er}, 32'd0);
        check_val("wr2_full_rdata", rd, 32'h0);
        check_val("latency", lat, EXP_LAT);
        rd_chk("rd2_full", 4'd2, 3'b001, 32'hDEAD_BEEF, 1'b0);

        wr_chk("wr2_strb", 4'd2, 32'h1122_3344, 4'b0101, 3'b001, 1'b0);
        rd_chk("rd2_strb", 4'd2, 3'b001, 32'hDE22_BE44, 1'b0);

        rd_chk("rd15_id", 4'd15, 3'b001, ID_EXP, 1'b0);
        xfer("wr15", 4'd15, 1'b1, 32'h0BAD_0BAD, 4'hF, 3'b001, rd, er, lat);
        check_val("wr15_err", {31'd0, er}, 32'd1);
        check_val("wr15_rdata", rd, 32'h0);
        rd_chk("rd15_again", 4'd15, 3'b001, ID_EXP, 1'b0);
        rd_chk("rd15_unpriv", 4'd15, 3'b000, ID_EXP, 1'b0);

        wr_chk("wr9_unpriv", 4'd9, 32'h55AA_55AA, 4'hF, 3'b000, 1'b1);
        rd_chk("rd9_unchanged", 4'd9, 3'b001, 32'h0, 1'b0);
        wr_chk("wr9_priv", 4'd9, 32'h55AA_55AA, 4'hF, 3'b001, 1'b0);
        rd_chk("rd9_priv", 4'd9, 3'b001, 32'h55AA_55AA, 1'b0);
        rd_chk("rd9_unpriv", 4'd9, 3'b000, 32'h0, 1'b1);

        wr_chk("wr7_unpriv", 4'd7, 32'h0000_0077, 4'hF, 3'b000, 1'b0);
        rd_chk("rd7_unpriv", 4'd7, 3'b000, 32'h0000_0077, 1'b0);
        wr_chk("wr8_unpriv", 4'd8, 32'h8888_8888, 4'hF, 3'b000, 1'b1);
        wr_chk("wr14_unpriv", 4'd14, 32'hEEEE_EEEE, 4'hF, 3'b000, 1'b1);
        wr_chk("wr14_priv", 4'd14, 32'h0E0E_0E0E, 4'hF, 3'b001, 1'b0);
        rd_chk("rd14_priv", 4'd14, 3'b001, 32'h0E0E_0E0E, 1'b0);
        rd_chk("rd8_unchanged", 4'd8, 3'b001, 32'h0, 1'b0);

        // Another slave selected: this one must stay silent.
        sel = 2'b10; enable = 1'b0; write = 1'b1; addr = 4'd2; wdata = 32'hFFFF_FFFF;
        strb = 4'hF; prot = 3'b001;
        @(posedge clk); #1;
        enable = 1'b1;
        rdy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready) rdy_seen++;
        end
        check_val("desel_ready", rdy_seen, 0);
        bus_idle();
        @(negedge clk);
        rd_chk("rd2_desel", 4'd2, 3'b001, 32'hDE22_BE44, 1'b0);

        // Enable without a preceding setup phase is ignored.
        bus_idle();
        @(negedge clk);
        sel = 2'b01; enable = 1'b1; write = 1'b1; addr = 4'd3; wdata = 32'h1234_5678;
        strb = 4'hF; prot = 3'b001;
        rdy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready) rdy_seen++;
        end
        check_val("noset_ready", rdy_seen, 0);
        bus_idle();
        @(negedge clk);
        rd_chk("rd3_noset", 4'd3, 3'b001, 32'h0, 1'b0);

        // Select dropped after the access phase starts: transfer still completes.
        bus_idle();
        @(negedge clk);
        sel = 2'b01; enable = 1'b0; write = 1'b1; addr = 4'd4; wdata = 32'hCAFE_F00D;
        strb = 4'hF; prot = 3'b001;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        sel = 2'b00;
        rdy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready) rdy_seen++;
        end
        check_val("seldrop_ready", rdy_seen, 1);
        bus_idle();
        @(negedge clk);
        rd_chk("rd4_seldrop", 4'd4, 3'b001, 32'hCAFE_F00D, 1'b0);

        // Reset in the middle of a transfer returns to idle and clears the slots.
        bus_idle();
        @(negedge clk);
        sel = 2'b01; enable = 1'b0; write = 1'b1; addr = 4'd6; wdata = 32'h6666_6666;
        strb = 4'hF; prot = 3'b001;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        rdy_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready) rdy_seen++;
        end
        check_val("postrst_ready", rdy_seen, 0);
        bus_idle();
        @(negedge clk);
        rd_chk("rd6_postrst", 4'd6, 3'b001, 32'h0, 1'b0);
        rd_chk("rd2_postrst", 4'd2, 3'b001, 32'h0, 1'b0);
        bus_idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/apb_modport_slave.md
Name: apb_modport_slave

Overview:
- APB slave that implements the slave side of the team's APB interface: it samples addr/prot/sel/enable/write/wdata/strb and drives ready/rdata/slv_err.
- Contains a small word-addressed register file with byte-strobe writes, one read-only ID register and error signalling.
- Sits behind an APB master or bus fabric as a leaf peripheral, selected by one bit of the shared sel vector.

Parameters:
- ADDR_WIDTH, 3: the address bus is ADDR_WIDTH+1 bits (bits ADDR_WIDTH:0); word index; 2^(ADDR_WIDTH+1) = 16 register slots.
- SEL_WIDTH, 2: width of the sel vector.
- SEL_INDEX, 0: bit of sel that selects this slave.
- WRITE_WIDTH, 32: wdata width and register width.
- READ_WIDTH, WRITE_WIDTH: rdata width; register value is truncated or zero-extended to fit.
- ID_VALUE, 32'hA5B0_0001: constant returned by the last slot (index 15).
- Derived, not overridable: STRB_WIDTH = ceil(WRITE_WIDTH/8).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- addr, input, ADDR_WIDTH+1: word address.
- prot, input, 3: protection attributes.
- sel, input, SEL_WIDTH: slave selects.
- enable, input, 1: access phase.
- write, input, 1: 1 = write, 0 = read.
- wdata, input, WRITE_WIDTH: write data.
- strb, input, STRB_WIDTH: byte write strobes.
- ready, output, 1: transfer complete.
- rdata, output, READ_WIDTH: read data.
- slv_err, output, 1: transfer error.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - all output registers, ready, slv_err and rdata = 0;
  - FSM in IDLE;
  - register slots 0..14 = 0.
- Define mysel = sel[SEL_INDEX].
- FSM states and transitions:
  - IDLE: go to SETUP when mysel && !enable.
  - SETUP: capture addr, write, wdata, strb and prot. Go to ACCESS when mysel && enable; otherwise return to IDLE.
  - ACCESS: ready = 1 combinationally for this single cycle; the transfer completes at the next rising edge. Next state is SETUP if mysel && !enable, else IDLE.
- Zero wait states: ready rises in the first access cycle. ready is 0 in all other states.
- Write commit: happens at the completing edge.
  - Byte i of the slot is updated only when strb[i] = 1.
  - Partial top byte (WRITE_WIDTH not a multiple of 8): strb[STRB_WIDTH-1] covers the remaining bits.
- Read: rdata = slot value, driven while ready = 1; it is 0 whenever ready = 0.
- Errors: slv_err = 1 together with ready when either condition holds:
  - a write targets slot 15 (ID register);
  - prot[0] = 0 (unprivileged) and addr is 8..14 (privileged bank).
  On error, registers are unchanged and rdata = 0.
- Reads of slot 15 always return ID_VALUE with no error.
- Protocol violation: if enable is seen high without a preceding SETUP (FSM in IDLE), the access is ignored; the FSM stays in IDLE and ready stays 0.
- If mysel drops while in ACCESS, the transfer still completes in that cycle (ready = 1 and any write commits).
- reset high mid-transfer: the FSM returns to IDLE at that edge and any pending write is discarded.
- Back-to-back transfers: ACCESS goes directly to SETUP.

Optional Feature:
- Macro: APB_SLAVE_WAIT_STATE_EN.
- When defined:
  - an extra WAIT state is inserted between SETUP and ACCESS;
  - for the first access-phase cycle ready = 0, and ready rises in the second;
  - commit, read data and error timing shift by one cycle.
- When undefined: zero-wait behaviour exactly as described above.

Test Plan:
- Reset: assert reset for 2 cycles -> ready = 0, slv_err = 0, rdata = 0; read of slot 3 returns 0.
- Full write then read: write addr 2, wdata 32'hDEAD_BEEF, strb 4'hF, prot 3'b001 -> ready = 1 in the access cycle with slv_err = 0; subsequent read of addr 2 returns 32'hDEAD_BEEF.
- Byte strobes: slot 2 = 32'hDEAD_BEEF; write 32'h1122_3344 with strb 4'b0101 -> read returns 32'hDE22_BE44.
- ID register: read addr 15 -> 32'hA5B0_0001, slv_err = 0. Write addr 15 -> slv_err = 1; a re-read still returns 32'hA5B0_0001.
- Privilege: write addr 9 with prot 3'b000 -> slv_err = 1 and slot unchanged. The same write with prot 3'b001 succeeds.
- Deselected and wait states:
  - sel[SEL_INDEX] = 0 with other sel bits set -> ready never asserts and slots are unchanged;
  - with APB_SLAVE_WAIT_STATE_EN defined, ready asserts exactly 2 cycles after SETUP.
